// File: rtl/act_pkg.sv
// Shared definitions for the activation stream unit: mode encodings and
// the frame beat-count helper.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_t;

  function automatic int calc_beats(input int elems, input int lanes);
    return (elems + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Combinational activation of a single signed element; a cleared keep
// forces the result to zero so padding lanes leave the unit clean.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  act_mode_t                mode,
  input  logic signed [DATA_W-1:0] clip,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     keep,
  output logic signed [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    if (keep) begin
      case (mode)
        ACT_BYPASS: y = x;
        ACT_RELU:   y = x[DATA_W-1] ? '0 : x;
        ACT_LEAKY:  y = x[DATA_W-1] ? (x >>> LEAK_SHIFT) : x;
        ACT_CLIP: begin
          // a negative ceiling makes every result zero
          if (!x[DATA_W-1] && !clip[DATA_W-1]) y = (x > clip) ? clip : x;
        end
        default:    y = '0;
      endcase
    end
  end

endmodule

// File: rtl/act_stream_unit.sv
// Two-stage streaming activation unit: stage 1 captures the beat with its
// frame config and position, stage 2 holds the activated result.
module act_stream_unit
  import act_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LANES       = 4,
  parameter int FRAME_ELEMS = 288,
  parameter int LEAK_SHIFT  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               cfg_mode,
  input  logic [DATA_W-1:0]        cfg_clip,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*DATA_W-1:0]  out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_last,
  output logic                     frame_done
);

  localparam int BEATS      = calc_beats(FRAME_ELEMS, LANES);
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST_LANES = FRAME_ELEMS - (BEATS - 1) * LANES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]        beat_cnt;
  act_mode_t               frame_mode;
  logic [DATA_W-1:0]       frame_clip;

  logic                    s1_valid;
  logic [LANES*DATA_W-1:0] s1_data;
  logic                    s1_last;
  act_mode_t               s1_mode;
  logic [DATA_W-1:0]       s1_clip;

  logic                    s1_adv;
  logic                    in_fire;
  logic                    first_beat;
  logic [LANES-1:0]        lane_keep;
  logic [LANES*DATA_W-1:0] act_data;

  assign s1_adv     = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_adv;
  assign in_fire    = in_valid && in_ready;
  assign first_beat = (beat_cnt == '0);
  assign frame_done = out_valid && out_ready && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      frame_mode <= ACT_BYPASS;
      frame_clip <= '0;
    end else if (in_fire) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      if (first_beat) begin
        frame_mode <= act_mode_t'(cfg_mode);
        frame_clip <= cfg_clip;
      end
    end
  end

  // Beat 0 takes the live config; the rest of the frame uses the latched copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      s1_mode  <= ACT_BYPASS;
      s1_clip  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_last <= (beat_cnt == LAST_BEAT);
        s1_mode <= first_beat ? act_mode_t'(cfg_mode) : frame_mode;
        s1_clip <= first_beat ? cfg_clip : frame_clip;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_keep[k] = (k < LAST_LANES) ? 1'b1 : !s1_last;

    act_lane #(
      .DATA_W    (DATA_W),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .mode(s1_mode),
      .clip(s1_clip),
      .x   (s1_data[k*DATA_W +: DATA_W]),
      .keep(lane_keep[k]),
      .y   (act_data[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= act_data;
        out_keep <= lane_keep;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: doc/act_stream_unit.md
ACT_STREAM_UNIT -- requirements
Module: act_stream_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, signed two's-complement element width.
REQ-002 SHALL have parameter LANES, default 4, elements per beat.
REQ-003 SHALL have parameter FRAME_ELEMS, default 288, elements per frame (6x6x8).
REQ-004 SHALL have parameter LEAK_SHIFT, default 3, leaky slope = 2^-LEAK_SHIFT.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_mode  input  2  0=bypass, 1=ReLU, 2=leaky ReLU, 3=clipped ReLU.
REQ-008 SHALL have port cfg_clip  input  DATA_W  signed clip ceiling for mode 3.
REQ-009 SHALL have port in_valid  input  1  input beat valid.
REQ-010 SHALL have port in_ready  output  1  input beat accepted when in_valid&in_ready.
REQ-011 SHALL have port in_data  input  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port out_valid  output  1  output beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_data  output  LANES*DATA_W  activated lanes, same packing.
REQ-015 SHALL have port out_keep  output  LANES  per-lane element-valid mask.
REQ-016 SHALL have port out_last  output  1  final beat of frame.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse on final-beat output handshake.

Function
REQ-018 SHALL process frames of BEATS = ceil(FRAME_ELEMS/LANES) beats, counting accepted input beats 0..BEATS-1, wrapping to 0 after BEATS-1.
REQ-019 SHALL sample cfg_mode and cfg_clip on acceptance of beat 0 and apply them unchanged to all beats of that frame; changes mid-frame are ignored.
REQ-020 SHALL compute per lane: bypass x; ReLU max(x,0); leaky x>=0 ? x : x>>>LEAK_SHIFT (arithmetic, rounds toward minus infinity); clipped min(max(x,0),cfg_clip), result 0 when cfg_clip<0.
REQ-021 SHALL be a two-stage pipeline (stage 1 register input plus frame tag, stage 2 register activated result); latency 2 cycles from input handshake to out_valid when unstalled.
REQ-022 SHALL sustain one beat per cycle when out_ready is held high.
REQ-023 SHALL drive in_ready high iff stage 1 is empty or stage 1 advances this cycle; stage 1 advances iff stage 2 is empty or out_ready is high.
REQ-024 SHALL hold out_data, out_keep, out_last stable while out_valid=1 and out_ready=0; no beat lost or duplicated.
REQ-025 SHALL assert out_last only on beat BEATS-1; out_keep all-ones on other beats; on last beat lanes with index >= FRAME_ELEMS-(BEATS-1)*LANES SHALL have keep=0 and data=0.
REQ-026 SHALL pulse frame_done for exactly one cycle when out_valid&out_ready&out_last.
REQ-027 SHALL ignore in_data when in_valid=0; out_ready toggling while out_valid=0 SHALL have no effect.

Reset
REQ-028 SHALL on rst_n low asynchronously clear both stage valid flags, beat counter, latched config (mode 0, clip 0), out_data, out_keep, out_last, frame_done, out_valid to 0; in_ready SHALL be 1 from first clock after reset release.
REQ-029 SHALL discard any partial frame on reset mid-operation; next accepted beat is beat 0.

Structure
REQ-030 SHALL place mode encodings (ACT_BYPASS..ACT_CLIP) and a BEATS helper function in shared package act_pkg.
REQ-031 SHALL instantiate one sub-module act_lane (combinational single-element activation) LANES times.

Verification
REQ-032 SHALL verify ReLU/leaky, DATA_W=32, LANE values {-16,-1,0,100}: mode1 -> {0,0,0,100}; mode2 -> {-2,-1,0,100}.
REQ-033 SHALL verify clip mode, cfg_clip=50, inputs {-5,25,50,1000} -> {0,25,50,50}; cfg_clip=-1 -> all 0.
REQ-034 SHALL verify FRAME_ELEMS=10, LANES=4: 3 beats, last beat out_keep=4'b0011, lanes 2-3 zero, out_last and frame_done once per frame.
REQ-035 SHALL verify random out_ready at 30% duty with continuous input: output stream equals reference model, no loss/duplication, stable data under stall.
REQ-036 SHALL verify cfg_mode changed 1->3 at beat 5 of a frame: frame stays ReLU; next frame uses clip.
REQ-037 SHALL verify rst_n asserted mid-frame at beat 20: outputs zero immediately, next frame out_last after exactly BEATS beats.
